// File: rtl/soc_system_mutex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_mutex_pkg
// Brief    : Shared types and constants for the Avalon-MM hardware mutex client.
// Revision : 1.0
// ============================================================================
package soc_system_mutex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLAIM   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_HELD    = 3'd4,
        ST_FREE    = 3'd5
    } state_t;

    // Field positions within the 32-bit mutex word {owner, value}
    localparam int OWNER_MSB = 31;
    localparam int OWNER_LSB = 16;
    localparam int VALUE_MSB = 15;
    localparam int VALUE_LSB = 0;

    localparam logic MUTEX_ADDR = 1'b0;
    localparam logic RESET_ADDR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/soc_system_mutex_client.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_mutex_client
// Brief    : Acquires/releases the Avalon-MM hardware mutex for fabric logic
//            via claim-write, read-back, compare, backoff and retry.
// Revision : 1.0
// ============================================================================
module soc_system_mutex_client
    import soc_system_mutex_pkg::*;
#(
    parameter logic [15:0] OWNER_ID       = 16'h0001,
    parameter logic [15:0] LOCK_VALUE     = 16'h0001,
    parameter logic [7:0]  BACKOFF_CYCLES = 8'd8,
    parameter logic [7:0]  MAX_RETRIES    = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        acquire,
    input  logic        release_req,
    output logic        locked,
    output logic        busy,
    output logic        fail,
    output logic [15:0] owner_seen,
    output logic        avm_address,
    output logic        avm_chipselect,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [31:0] CLAIM_WORD = {OWNER_ID, LOCK_VALUE};
    localparam logic [31:0] FREE_WORD  = {OWNER_ID, 16'h0000};

    state_t      state_q,      state_d;
    logic [7:0]  retry_q,      retry_d;
    logic [7:0]  backoff_q,    backoff_d;
    logic [15:0] owner_seen_q, owner_seen_d;
    logic        fail_q,       fail_d;
    logic        locked_q,     locked_d;
    logic [7:0]  retry_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            retry_q      <= 8'd0;
            backoff_q    <= 8'd0;
            owner_seen_q <= 16'd0;
            fail_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            backoff_q    <= backoff_d;
            owner_seen_q <= owner_seen_d;
            fail_q       <= fail_d;
            locked_q     <= locked_d;
        end
    end

    // Saturating so a huge MAX_RETRIES never sees the count wrap past it
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        backoff_d    = backoff_q;
        owner_seen_d = owner_seen_q;
        fail_d       = 1'b0;
        // Registered one cycle behind HELD so it rises after the mutex confirms
        locked_d     = (state_q == ST_HELD);

        case (state_q)
            ST_IDLE: begin
                if (acquire) begin
                    state_d = ST_CLAIM;
                    retry_d = 8'd0;
                end
            end
            ST_CLAIM: begin
                if (!avm_waitrequest) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!avm_waitrequest) begin
                    if (avm_readdata == CLAIM_WORD) begin
                        state_d = ST_HELD;
                    end else begin
                        owner_seen_d = avm_readdata[OWNER_MSB:OWNER_LSB];
                        retry_d      = retry_inc;
                        if ((MAX_RETRIES != 8'd0) && (retry_inc == MAX_RETRIES)) begin
                            state_d = ST_IDLE;
                            fail_d  = 1'b1;
                        end else begin
                            state_d   = ST_BACKOFF;
                            backoff_d = BACKOFF_CYCLES - 8'd1;
                        end
                    end
                end
            end
            ST_BACKOFF: begin
                if (backoff_q == 8'd0) state_d = ST_CLAIM;
                else                   backoff_d = backoff_q - 8'd1;
            end
            ST_HELD: begin
                if (release_req) state_d = ST_FREE;
            end
            ST_FREE: begin
                if (!avm_waitrequest) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus strobes are a pure decode of the state register
    always_comb begin
        avm_chipselect = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = 32'd0;
        case (state_q)
            ST_CLAIM: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_writedata  = CLAIM_WORD;
            end
            ST_CHECK: begin
                avm_chipselect = 1'b1;
                avm_read       = 1'b1;
            end
            ST_FREE: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_writedata  = FREE_WORD;
            end
            default: ;
        endcase
    end

    assign avm_address = MUTEX_ADDR;
    assign busy        = (state_q == ST_CLAIM) || (state_q == ST_CHECK) ||
                         (state_q == ST_BACKOFF) || (state_q == ST_FREE);
    assign locked      = locked_q;
    assign fail        = fail_q;
    assign owner_seen  = owner_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_mutex_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_mutex_client
// Brief    : Self-checking bench with a behavioural mutex slave and a second
//            master, randomized stalls and contention lengths.
// Revision : 1.0
// ============================================================================
module tb_soc_system_mutex_client;

    localparam logic [31:0] C_CLAIM = 32'h0001_0001;
    localparam logic [31:0] C_FREE  = 32'h0001_0000;
    localparam int          C_BACKOFF = 4;
    localparam int          C_MAXRETRY = 3;

    logic        clk = 1'b0;
    logic        reset_n, acquire, release_req, waitreq;
    logic        locked, busy, fail;
    logic [15:0] owner_seen;
    logic        avm_address, avm_chipselect, avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;

    // Behavioural mutex: survives client reset, shared with a second master
    logic [31:0] mutex_word = 32'd0;
    logic        other_wr;
    logic [31:0] other_data;
    int          cyc = 0;
    int          n_wr = 0;
    int          n_claim = 0;
    int          claim_at [0:255];
    int          fail_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    soc_system_mutex_client #(
        .OWNER_ID       (16'h0001),
        .LOCK_VALUE     (16'h0001),
        .BACKOFF_CYCLES (8'(C_BACKOFF)),
        .MAX_RETRIES    (8'(C_MAXRETRY))
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .acquire         (acquire),
        .release_req     (release_req),
        .locked          (locked),
        .busy            (busy),
        .fail            (fail),
        .owner_seen      (owner_seen),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (waitreq)
    );

    always #5 clk = ~clk;

    assign avm_readdata = mutex_word;

    function automatic logic [31:0] mutex_next(input logic [31:0] cur, input logic [31:0] wd);
        if (cur[15:0] == 16'h0 || cur[31:16] == wd[31:16]) return wd;
        return cur;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_chipselect && avm_write && !waitreq) begin
            n_wr <= n_wr + 1;
            if (!avm_address) mutex_word <= mutex_next(mutex_word, avm_writedata);
            if (avm_writedata == C_CLAIM) begin
                if (n_claim < 256) claim_at[n_claim] <= cyc;
                n_claim <= n_claim + 1;
            end
        end else if (other_wr) begin
            mutex_word <= mutex_next(mutex_word, other_data);
        end
    end

    always @(negedge clk) if (fail) fail_cnt <= fail_cnt + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic other_write(input logic [31:0] d);
        other_wr   = 1'b1;
        other_data = d;
        @(negedge clk);
        other_wr   = 1'b0;
    endtask

    // Pulse acquire; stall k cycles in CLAIM and kc in CHECK; measure edges to locked
    task automatic acquire_measure(input int k, input int kc, input logic rel_too,
                                   output int lat, output int stable);
        acquire     = 1'b1;
        release_req = rel_too;
        @(posedge clk);
        lat    = 0;
        stable = 0;
        while (lat < 40) begin
            @(negedge clk);
            acquire     = 1'b0;
            release_req = 1'b0;
            if (locked) break;
            waitreq = (lat < k) || (lat >= k + 1 && lat < k + 1 + kc);
            if (avm_write && avm_writedata == C_CLAIM) stable++;
            lat++;
        end
        waitreq = 1'b0;
    endtask

    task automatic do_release(input logic acq_too);
        int w0;
        w0          = n_wr;
        release_req = 1'b1;
        acquire     = acq_too;
        @(negedge clk);
        release_req = 1'b0;
        acquire     = 1'b0;
        check_value("rel_locked_in_free", 32'(locked), 32'd1);
        check_value("rel_write_strobe", 32'(avm_write), 32'd1);
        check_value("rel_writedata", avm_writedata, C_FREE);
        check_value("rel_address", 32'(avm_address), 32'd0);
        @(negedge clk);
        check_value("rel_locked_after", 32'(locked), 32'd0);
        check_value("rel_busy_after", 32'(busy), 32'd0);
        check_value("rel_mutex_value", 32'(mutex_word[15:0]), 32'd0);
        check_value("rel_write_count", 32'(n_wr - w0), 32'd1);
    endtask

    initial begin
        int k, kc, lat, stable, r, c0, f0, w0, g;
        reset_n = 1'b0; acquire = 1'b0; release_req = 1'b0; waitreq = 1'b0;
        other_wr = 1'b0; other_data = 32'd0;
        repeat (3) @(negedge clk);
        check_value("rst_locked", 32'(locked), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_fail", 32'(fail), 32'd0);
        check_value("rst_owner_seen", 32'(owner_seen), 32'd0);
        check_value("rst_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 32'd0);
        check_value("rst_writedata", avm_writedata, 32'd0);
        check_value("rst_address", 32'(avm_address), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // release in IDLE does nothing
        w0 = n_wr;
        release_req = 1'b1;
        @(negedge clk);
        release_req = 1'b0;
        repeat (2) @(negedge clk);
        check_value("idle_release_writes", 32'(n_wr - w0), 32'd0);
        check_value("idle_release_busy", 32'(busy), 32'd0);

        // Uncontended acquires with random bus stalls
        for (int it = 0; it < 4; it++) begin
            k  = int'($urandom_range(0, 4));
            kc = int'($urandom_range(0, 3));
            w0 = n_wr;
            acquire_measure(k, kc, (it == 2), lat, stable);
            check_value("acq_latency", 32'(lat), 32'(3 + k + kc));
            check_value("claim_stable_cycles", 32'(stable), 32'(k + 1));
            check_value("acq_mutex_word", mutex_word, C_CLAIM);
            check_value("acq_write_count", 32'(n_wr - w0), 32'd1);
            if (it == 0) begin
                w0 = n_wr;
                acquire = 1'b1;
                @(negedge clk);
                acquire = 1'b0;
                repeat (3) @(negedge clk);
                check_value("held_acquire_writes", 32'(n_wr - w0), 32'd0);
                check_value("held_still_locked", 32'(locked), 32'd1);
            end
            do_release(it == 1);
            @(negedge clk);
        end

        // Contention: second master holds, releases after r failed checks
        for (int it = 0; it < 2; it++) begin
            r = int'($urandom_range(1, 2));
            other_write(32'h0002_0005);
            check_value("contend_mutex_taken", mutex_word, 32'h0002_0005);
            c0 = n_claim;
            f0 = fail_cnt;
            acquire = 1'b1;
            @(negedge clk);
            acquire = 1'b0;
            g = 0;
            while (n_claim < c0 + r && g < 100) begin @(negedge clk); g++; end
            check_value("contend_claim_wait", 32'(n_claim - c0), 32'(r));
            repeat (3) @(negedge clk);
            check_value("contend_owner_seen", 32'(owner_seen), 32'h0002);
            check_value("contend_not_locked", 32'(locked), 32'd0);
            check_value("contend_busy", 32'(busy), 32'd1);
            other_write(32'h0002_0000);
            g = 0;
            while (!locked && g < 80) begin @(negedge clk); g++; end
            check_value("contend_locked", 32'(locked), 32'd1);
            check_value("contend_claims", 32'(n_claim - c0), 32'(r + 1));
            for (int j = 1; j <= r; j++)
                check_value("contend_retry_interval",
                            32'(claim_at[c0 + j] - claim_at[c0 + j - 1]), 32'(C_BACKOFF + 2));
            check_value("contend_no_fail", 32'(fail_cnt - f0), 32'd0);
            do_release(1'b0);
            @(negedge clk);
        end

        // Retry limit exhausted
        other_write(32'h0002_0005);
        c0 = n_claim;
        f0 = fail_cnt;
        acquire = 1'b1;
        @(negedge clk);
        acquire = 1'b0;
        g = 0;
        while (fail_cnt == f0 && g < 100) begin @(negedge clk); g++; end
        repeat (12) @(negedge clk);
        check_value("limit_claims", 32'(n_claim - c0), 32'(C_MAXRETRY));
        check_value("limit_fail_pulses", 32'(fail_cnt - f0), 32'd1);
        check_value("limit_busy", 32'(busy), 32'd0);
        check_value("limit_locked", 32'(locked), 32'd0);
        check_value("limit_owner_seen", 32'(owner_seen), 32'h0002);

        // Reset during BACKOFF
        c0 = n_claim;
        acquire = 1'b1;
        @(negedge clk);
        acquire = 1'b0;
        g = 0;
        while (n_claim < c0 + 1 && g < 50) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        check_value("bk_busy_before_rst", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_value("async_rst_busy", 32'(busy), 32'd0);
        check_value("async_rst_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 32'd0);
        check_value("async_rst_writedata", avm_writedata, 32'd0);
        check_value("async_rst_owner_seen", 32'(owner_seen), 32'd0);
        check_value("async_rst_locked_fail", {30'd0, locked, fail}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        other_write(32'h0002_0000);
        acquire_measure(0, 0, 1'b0, lat, stable);
        check_value("post_rst_latency", 32'(lat), 32'd3);
        check_value("post_rst_claim_cycles", 32'(stable), 32'd1);
        do_release(1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
